// File: rtl/alu_frame_deserializer.sv
// Deserialises A/B data frames and a CTL frame from sin into checked ALU operands.
// Optional inter-frame idle timeout is enabled by defining ALU_DESER_TIMEOUT_EN.
module alu_frame_deserializer #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CNT_W       = 6,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [2:0]        op_out,
  output logic              out_valid,
  output logic [5:0]        err_flags,
  output logic              err_valid
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam logic [CNT_W-1:0] NUM_A    = CNT_W'(BYTES);
  localparam logic [CNT_W-1:0] NUM_DATA = CNT_W'(2 * BYTES);
  localparam logic [5:0] ERR_DATA = 6'b100100;
  localparam logic [5:0] ERR_CRC  = 6'b010010;
  localparam logic [5:0] ERR_OP   = 6'b001001;

  if ((DATA_W % 8 != 0) || (DATA_W < 8)) begin : g_bad_data_w
    $error("DATA_W must be a non-zero multiple of 8");
  end
  if ((2 ** CNT_W) <= (2 * BYTES)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for 2*BYTES frames");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  typedef enum logic [2:0] {StIdle, StStart, StRead, StStop, StCheck, StError} state_e;

  state_e             state_q, state_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic               is_ctl_q, is_ctl_d;
  logic [DATA_W-1:0]  a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  // The CTL MSB is always 0 and simply falls off the top of this 7-bit shifter.
  logic [6:0]         ctl_sh_q, ctl_sh_d;
  logic [3:0]         ones_cnt_q, ones_cnt_d;
  logic [DATA_W-1:0]  a_q, a_d, b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic               out_valid_q, out_valid_d, err_valid_q, err_valid_d;
  logic [5:0]         err_flags_q, err_flags_d;
  logic               raise, clear;
  logic [5:0]         flag;
  logic [3:0]         crc;
  logic [2*DATA_W+3:0] crc_msg;
  logic               op_ok;

`ifdef ALU_DESER_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idle_cnt_q <= '0;
    else      idle_cnt_q <= idle_cnt_d;
  end
`endif

  // CRC4 x^4+x+1, init 0, leftmost message bit first.
  assign crc_msg = {b_sh_q, a_sh_q, 1'b1, ctl_sh_q[6:4]};
  always_comb begin
    crc = '0;
    for (int i = 2 * DATA_W + 3; i >= 0; i--) begin
      crc = {crc[2:0], 1'b0} ^ ({4{crc[3] ^ crc_msg[i]}} & 4'b0011);
    end
  end

  assign op_ok = ctl_sh_q[6:4] inside {3'b000, 3'b001, 3'b100, 3'b101};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    frame_cnt_d = frame_cnt_q;
    is_ctl_d    = is_ctl_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    ctl_sh_d    = ctl_sh_q;
    ones_cnt_d  = ones_cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    out_valid_d = 1'b0;
    err_valid_d = 1'b0;
    err_flags_d = err_flags_q;
    raise       = 1'b0;
    clear       = 1'b0;
    flag        = '0;
`ifdef ALU_DESER_TIMEOUT_EN
    idle_cnt_d  = idle_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!sin) state_d = StStart;
`ifdef ALU_DESER_TIMEOUT_EN
        if (!sin || frame_cnt_q == '0) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          idle_cnt_d = '0;
          raise      = 1'b1;
          flag       = ERR_DATA;
        end else begin
          idle_cnt_d = idle_cnt_q + TO_W'(1);
        end
`endif
      end
      StStart: begin
        is_ctl_d  = sin;
        bit_cnt_d = '0;
        if (!sin && frame_cnt_q == NUM_DATA) begin
          raise      = 1'b1;
          flag       = ERR_DATA;
          ones_cnt_d = '0;
          state_d    = StError;
        end else begin
          state_d = StRead;
        end
      end
      StRead: begin
        if (is_ctl_q)                ctl_sh_d = {ctl_sh_q[5:0], sin};
        else if (frame_cnt_q < NUM_A) a_sh_d  = {a_sh_q[DATA_W-2:0], sin};
        else                          b_sh_d  = {b_sh_q[DATA_W-2:0], sin};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = StStop;
      end
      StStop: begin
        if (!sin) begin
          raise      = 1'b1;
          flag       = ERR_DATA;
          ones_cnt_d = '0;
          state_d    = StError;
        end else if (is_ctl_q) begin
          state_d = StCheck;
        end else begin
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
          state_d     = StIdle;
        end
      end
      StCheck: begin
        state_d = StIdle;
        clear   = 1'b1;
        if (frame_cnt_q != NUM_DATA) begin
          raise = 1'b1;
          flag  = ERR_DATA;
        end else if (crc != ctl_sh_q[3:0]) begin
          raise = 1'b1;
          flag  = ERR_CRC;
        end else if (!op_ok) begin
          raise = 1'b1;
          flag  = ERR_OP;
        end else begin
          a_d         = a_sh_q;
          b_d         = b_sh_q;
          op_d        = ctl_sh_q[6:4];
          out_valid_d = 1'b1;
        end
      end
      StError: begin
        // Drain until the line has been idle for a full frame length.
        if (!sin) begin
          ones_cnt_d = '0;
        end else if (ones_cnt_q == 4'd10) begin
          ones_cnt_d = '0;
          state_d    = StIdle;
        end else begin
          ones_cnt_d = ones_cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (raise) begin
      err_valid_d = 1'b1;
      err_flags_d = flag;
      clear       = 1'b1;
    end
    if (clear) begin
      frame_cnt_d = '0;
      a_sh_d      = '0;
      b_sh_d      = '0;
      ctl_sh_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      frame_cnt_q <= '0;
      is_ctl_q    <= 1'b0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      ctl_sh_q    <= '0;
      ones_cnt_q  <= '0;
      a_q         <= '1;
      b_q         <= '1;
      op_q        <= 3'b111;
      out_valid_q <= 1'b0;
      err_valid_q <= 1'b0;
      err_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      is_ctl_q    <= is_ctl_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      ctl_sh_q    <= ctl_sh_d;
      ones_cnt_q  <= ones_cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      out_valid_q <= out_valid_d;
      err_valid_q <= err_valid_d;
      err_flags_q <= err_flags_d;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign op_out    = op_q;
  assign out_valid = out_valid_q;
  assign err_valid = err_valid_q;
  assign err_flags = err_flags_q;

endmodule

// File: doc/alu_frame_deserializer.md
Name: alu_frame_deserializer

Overview:
- Parametrised successor of the ALU serial-input deserializer.
- Receives 11-bit UART-like frames on `sin`: data frames carry operands A then B, and a final CTL frame carries OP and CRC4.
- Validates the packet (framing, byte count, CRC, opcode) and presents A/B/OP with a one-cycle valid strobe, or an error strobe with flags.
- Sits between the serial pad and the ALU core.

Parameters:
- DATA_W, 32, operand width in bits; must be a multiple of 8 and at least 8; BYTES = DATA_W/8 frames per operand.
- CNT_W, 6, width of the frame counter; must satisfy 2^CNT_W > 2*BYTES.
- TIMEOUT_CYC, 1024, maximum idle cycles between frames of one packet (used only with the optional feature).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- sin  in  1  serial input, idle high.
- a_out  out  DATA_W  operand A.
- b_out  out  DATA_W  operand B.
- op_out  out  3  opcode.
- out_valid  out  1  one-cycle strobe: a_out/b_out/op_out updated.
- err_flags  out  6  {ERR_DATA,ERR_CRC,ERR_OP, parity copy of same 3 bits}.
- err_valid  out  1  one-cycle strobe: err_flags updated.

Behaviour:
- Interface rule: one clock; reset is asynchronous and active-low.
- Reset values: a_out=b_out all ones; op_out=3'b111; err_flags=0; out_valid=0; err_valid=0; FSM=IDLE; all counters and shift registers 0.
- Frame format, 1 bit per clk, MSB first: start(0), type(0=data, 1=ctl), 8 payload bits, stop(1).
- CTL payload: [7]=0, [6:4]=OP, [3:0]=CRC.
- Packet: BYTES data frames for A, then BYTES data frames for B, then one CTL frame.
- FSM states:
  - IDLE: sin=0 -> START.
  - START: samples the type bit -> READ; bit_cnt=0.
  - READ: 8 payload bits shifted into A, B or CTL, chosen by frame_cnt -> STOP.
  - STOP: samples the stop bit.
  - CHECK: one cycle.
  - ERROR: drain.
- STOP with sin=1, data frame: frame_cnt+1 -> IDLE.
- STOP with sin=1, CTL frame -> CHECK.
- STOP with sin=0 -> ERROR with ERR_DATA.
- Type bit = data while frame_cnt == 2*BYTES (too many data frames) -> ERROR with ERR_DATA.
- CTL frame with frame_cnt < 2*BYTES: received fully; in CHECK report ERR_DATA only.
- CHECK, error priority ERR_DATA > ERR_CRC > ERR_OP:
  - CRC4, polynomial x^4+x+1, init 0, computed over {B, A, 1'b1, OP}, 2*DATA_W+4 bits, leftmost bit first; combinational bit loop.
  - Valid OP: 000 AND, 001 OR, 100 ADD, 101 SUB; any other value -> ERR_OP.
  - Pass: next edge loads a_out/b_out/op_out, out_valid=1 for exactly 1 cycle, err_valid=0.
- Latency: the edge sampling the CTL stop bit enters CHECK; the following edge asserts out_valid/err_valid.
- Error flag encodings: ERR_DATA=100100, ERR_CRC=010010, ERR_OP=001001; only the highest-priority flag is set.
- Any error: err_valid=1 for 1 cycle; a_out/b_out/op_out hold their previous values; frame_cnt and shift registers cleared.
- ERROR state: ignore sin until it has been 1 for 11 consecutive cycles, then go to IDLE. Not entered from CHECK, which returns directly to IDLE.
- A start bit in the cycle right after CHECK is accepted; back-to-back packets need no gap.
- Async reset mid-packet: immediate return to reset values; a partial packet is discarded.
- out_valid and err_valid are never high in the same cycle.

Optional Feature:
- Macro: ALU_DESER_TIMEOUT_EN.
- Defined: an idle counter runs in IDLE while frame_cnt != 0. When it reaches TIMEOUT_CYC -> err_valid with ERR_DATA, frame_cnt cleared, stay in IDLE. Counter resets on each start bit.
- Undefined: no counter logic; a partial packet waits indefinitely for further frames.

Test Plan:
- A=32'h00000001, B=32'h00000002, OP=100, correct CRC (bench model) -> one out_valid pulse, a_out=1, b_out=2, op_out=100, err_valid never set.
- Same packet with CRC field XOR 4'h1 -> err_valid, err_flags=010010; a_out/b_out/op_out keep reset values FFFFFFFF/FFFFFFFF/111.
- Valid CRC but OP=010 -> err_flags=001001; then a good packet back-to-back -> out_valid with its values.
- Stop bit 0 in the 3rd data frame -> ERR_DATA (100100) right after that frame; a new packet after 11 idle-high cycles -> accepted.
- CTL frame after only 7 data frames -> err_flags=100100; a 9th data frame before CTL -> err_flags=100100.
- rst low during the 5th data frame, then a full good packet -> outputs match the new packet. With ALU_DESER_TIMEOUT_EN and TIMEOUT_CYC=16: 2 data frames then idle -> ERR_DATA after 16 cycles.
